wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port of the writeback stage among three result sources: ALU (fixed-latency, cannot stall), load/store unit (LSU, valid/ready) and mul/div unit (MDU, valid/ready).
- Registers the winning result onto the writeback bus (wb_en/wb_rd/wb_data) that feeds the register file and the writeback-stage agent.
- Prevents LSU/MDU starvation by requesting a one-cycle ALU issue hold upstream.

Parameters:
- XLEN, 32, data width of results and wb_data
- REG_AW, 5, register address width
- STARVE_LIMIT, 4, consecutive denied cycles before pipe_hold is raised (legal range 1..15)

Ports:
- clk  input  1  core clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  kill speculative ALU result this cycle; clears starvation state
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  REG_AW  ALU destination register
- alu_data  input  XLEN  ALU result
- lsu_valid  input  1  load data present
- lsu_ready  output  1  LSU result accepted this cycle
- lsu_rd  input  REG_AW  load destination
- lsu_data  input  XLEN  load data
- mdu_valid  input  1  mul/div result present
- mdu_ready  output  1  MDU result accepted this cycle
- mdu_rd  input  REG_AW  mul/div destination
- mdu_data  input  XLEN  mul/div result
- pipe_hold  output  1  registered; upstream must not present alu_valid in a cycle where pipe_hold=1
- wb_en  output  1  registered register-file write enable
- wb_rd  output  REG_AW  registered write address
- wb_data  output  XLEN  registered write data
- err_alu_drop  output  1  sticky; set when an ALU result is dropped

Behaviour:
- Reset (reset=0, async): wb_en=0, wb_rd=0, wb_data=0, pipe_hold=0, err_alu_drop=0, starve_cnt=0, rr_ptr=0 (LSU preferred).
- Effective ALU request: alu_req = alu_valid & ~flush & ~pipe_hold.
- Grant is combinational per cycle, priority: alu_req > round-robin(LSU, MDU).
- Round-robin: if both lsu_valid and mdu_valid are high and ALU is not granted, grant LSU when rr_ptr=0, else MDU. If only one is valid, grant it.
- rr_ptr updates only on an LSU/MDU grant: set to 1 after an LSU grant, 0 after an MDU grant.
- lsu_ready/mdu_ready are combinational and equal their grant; they never go high without the matching valid.
- Write latency is 1 cycle: the granted source's rd/data are captured at the next rising edge.
  - wb_en=1 iff a grant occurred and the granted rd != 0.
  - Grant with rd=0: source is still accepted (ready=1), but wb_en=0 and wb_rd/wb_data still update.
- No grant: wb_en=0; wb_rd/wb_data hold their previous values.
- Starvation counter (4 bits, saturating at STARVE_LIMIT):
  - increments when (lsu_valid|mdu_valid) and ALU is granted;
  - clears on any LSU/MDU grant, on flush, or when no LSU/MDU valid.
- pipe_hold:
  - set at the edge where the incremented count equals STARVE_LIMIT;
  - held for exactly one cycle, then clears with starve_cnt=0.
  - During the hold cycle the ALU is masked, so a pending LSU/MDU result is guaranteed a grant.
- Protocol violation: alu_valid=1 while pipe_hold=1 and flush=0 → ALU result discarded, err_alu_drop set (sticky until reset).
- flush:
  - suppresses only the ALU contribution that cycle; LSU/MDU arbitration proceeds normally;
  - clears starve_cnt and pipe_hold at the next edge. pipe_hold set concurrently with flush loses, so pipe_hold=0.
- Reset asserted mid-transfer: the in-flight grant is lost, wb_en drops immediately, ready outputs go 0 while reset is low.

Test Plan:
- Reset then idle: all valids 0 → wb_en=0, lsu_ready=mdu_ready=0, pipe_hold=0 indefinitely.
- Contention: alu_valid=1 (rd=3, data=0xA5A5A5A5) with lsu_valid=1 (rd=4) → cycle 0: lsu_ready=0; next cycle: wb_en=1, wb_rd=3, wb_data=0xA5A5A5A5. Drop alu_valid → LSU granted, next cycle wb_rd=4.
- Round-robin: lsu_valid=mdu_valid=1 held, no ALU → grants alternate LSU, MDU, LSU, MDU starting with LSU after reset; each grant produces wb_en=1 one cycle later.
- Starvation with STARVE_LIMIT=4: alu_valid=1 every cycle, mdu_valid=1 (rd=7, data=0x12345678) →
  - 4 ALU grants, then pipe_hold=1 for one cycle;
  - bench drops alu_valid → mdu_ready=1, next cycle wb_rd=7, wb_data=0x12345678;
  - pipe_hold=0 after.
- rd=0 and flush: LSU grant with lsu_rd=0 → lsu_ready=1, next cycle wb_en=0. alu_valid=1 with flush=1 → no ALU write, LSU granted instead if valid.
- Violation: force alu_valid=1 during a pipe_hold cycle → ALU not written, err_alu_drop=1 and stays 1 until reset=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: ALU has priority, LSU/MDU share the port round-robin.
// An ALU issue hold is raised upstream after a run of denied LSU/MDU cycles.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [REG_AW-1:0] mdu_rd,
    input  logic [XLEN-1:0]   mdu_data,
    output logic              pipe_hold,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              err_alu_drop
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic              alu_req_s;
    logic              gnt_lsu_s;
    logic              gnt_mdu_s;
    logic              any_gnt_s;
    logic [REG_AW-1:0] sel_rd_s;
    logic [XLEN-1:0]   sel_data_s;
    logic [3:0]        cnt_inc_s;
    logic [3:0]        starve_nxt_s;
    logic              hold_nxt_s;
    logic [3:0]        starve_cnt_r;
    logic              rr_ptr_r;

    // Per-cycle grant: unmasked ALU first, then LSU/MDU round-robin
    always_comb begin
        alu_req_s = alu_valid & ~flush & ~pipe_hold;
        gnt_lsu_s = 1'b0;
        gnt_mdu_s = 1'b0;
        if (alu_req_s) begin
            gnt_lsu_s = 1'b0;
            gnt_mdu_s = 1'b0;
        end else if (lsu_valid && mdu_valid) begin
            gnt_lsu_s = ~rr_ptr_r;
            gnt_mdu_s = rr_ptr_r;
        end else begin
            gnt_lsu_s = lsu_valid;
            gnt_mdu_s = mdu_valid;
        end
    end

    // Winning source's write address and data
    always_comb begin
        any_gnt_s  = alu_req_s | gnt_lsu_s | gnt_mdu_s;
        sel_rd_s   = {REG_AW{1'b0}};
        sel_data_s = {XLEN{1'b0}};
        if (alu_req_s) begin
            sel_rd_s   = alu_rd;
            sel_data_s = alu_data;
        end else if (gnt_lsu_s) begin
            sel_rd_s   = lsu_rd;
            sel_data_s = lsu_data;
        end else if (gnt_mdu_s) begin
            sel_rd_s   = mdu_rd;
            sel_data_s = mdu_data;
        end else begin
            sel_rd_s   = {REG_AW{1'b0}};
            sel_data_s = {XLEN{1'b0}};
        end
    end

    // Starvation tracking; the hold cycle masks the ALU so the count always clears after it
    always_comb begin
        cnt_inc_s    = (starve_cnt_r == LIMIT_C) ? starve_cnt_r : starve_cnt_r + 4'd1;
        starve_nxt_s = 4'd0;
        hold_nxt_s   = 1'b0;
        if (flush || gnt_lsu_s || gnt_mdu_s || !(lsu_valid || mdu_valid)) begin
            starve_nxt_s = 4'd0;
            hold_nxt_s   = 1'b0;
        end else if (alu_req_s) begin
            starve_nxt_s = cnt_inc_s;
            hold_nxt_s   = (cnt_inc_s == LIMIT_C);
        end else begin
            starve_nxt_s = 4'd0;
            hold_nxt_s   = 1'b0;
        end
    end

    // Ready outputs follow the grant and are forced low while reset is asserted
    assign lsu_ready = gnt_lsu_s & reset;
    assign mdu_ready = gnt_mdu_s & reset;

    // Writeback bus, round-robin pointer, starvation state and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_en        <= 1'b0;
            wb_rd        <= {REG_AW{1'b0}};
            wb_data      <= {XLEN{1'b0}};
            pipe_hold    <= 1'b0;
            err_alu_drop <= 1'b0;
            starve_cnt_r <= 4'd0;
            rr_ptr_r     <= 1'b0;
        end else begin
            wb_en <= any_gnt_s & (sel_rd_s != {REG_AW{1'b0}});
            if (any_gnt_s) begin
                wb_rd   <= sel_rd_s;
                wb_data <= sel_data_s;
            end else begin
                wb_rd   <= wb_rd;
                wb_data <= wb_data;
            end
            if (gnt_lsu_s) begin
                rr_ptr_r <= 1'b1;
            end else if (gnt_mdu_s) begin
                rr_ptr_r <= 1'b0;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            starve_cnt_r <= starve_nxt_s;
            pipe_hold    <= hold_nxt_s;
            err_alu_drop <= err_alu_drop | (alu_valid & pipe_hold & ~flush);
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        alu_valid, lsu_valid, mdu_valid;
    logic [4:0]  alu_rd, lsu_rd, mdu_rd;
    logic [31:0] alu_data, lsu_data, mdu_data;
    logic        lsu_ready, mdu_ready, pipe_hold, wb_en, err_alu_drop;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_pass  = 0;
    int n_total = 0;

    // Model state
    bit          m_hold, m_err, m_mdu_turn, m_wb_en;
    int          m_waited, m_win;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    logic        obs_lsu_rdy, obs_mdu_rdy;

    wb_port_arbiter #(.XLEN(32), .REG_AW(5), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .pipe_hold(pipe_hold), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_alu_drop(err_alu_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_hold = 0; m_err = 0; m_mdu_turn = 0; m_wb_en = 0;
        m_waited = 0; m_win = 0; m_wb_rd = '0; m_wb_data = '0;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
        alu_rd = 5'd0; lsu_rd = 5'd0; mdu_rd = 5'd0;
        alu_data = 32'd0; lsu_data = 32'd0; mdu_data = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        #1;
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_hold", pipe_hold, 0);
        check("rst_err", err_alu_drop, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
    endtask

    // One clock: readies checked mid-cycle, registered outputs checked just after the edge
    task automatic step();
        bit alu_wins, side_pending;
        @(negedge clk);
        alu_wins     = alu_valid && !flush && !m_hold;
        side_pending = lsu_valid || mdu_valid;
        if (alu_wins)                                   m_win = 1;
        else if (lsu_valid && !(mdu_valid && m_mdu_turn)) m_win = 2;
        else if (mdu_valid)                             m_win = 3;
        else                                            m_win = 0;
        obs_lsu_rdy = lsu_ready;
        obs_mdu_rdy = mdu_ready;
        check("lsu_ready", lsu_ready, (m_win == 2));
        check("mdu_ready", mdu_ready, (m_win == 3));
        @(posedge clk);
        if (alu_valid && m_hold && !flush) m_err = 1;
        m_wb_en = 0;
        if (m_win == 1) begin m_wb_rd = alu_rd; m_wb_data = alu_data; end
        if (m_win == 2) begin m_wb_rd = lsu_rd; m_wb_data = lsu_data; m_mdu_turn = 1; end
        if (m_win == 3) begin m_wb_rd = mdu_rd; m_wb_data = mdu_data; m_mdu_turn = 0; end
        if (m_win != 0) m_wb_en = (m_wb_rd != 0);
        if (flush || m_win != 1 || !side_pending) m_waited = 0;
        else m_waited = m_waited + 1;
        m_hold = !flush && (m_waited == LIMIT);
        #1;
        check("wb_en", wb_en, m_wb_en);
        check("wb_rd", wb_rd, m_wb_rd);
        check("wb_data", wb_data, m_wb_data);
        check("pipe_hold", pipe_hold, m_hold);
        check("err_alu_drop", err_alu_drop, m_err);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #2;
        do_reset();

        // Idle after reset
        repeat (5) step();

        // Contention: ALU beats LSU, then LSU goes through
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA5A5_A5A5;
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h0000_0044;
        step();
        check("cont_lsu_wait", obs_lsu_rdy, 0);
        check("cont_alu_en", wb_en, 1);
        check("cont_alu_rd", wb_rd, 3);
        check("cont_alu_data", wb_data, 32'hA5A5_A5A5);
        alu_valid = 0;
        step();
        check("cont_lsu_rdy", obs_lsu_rdy, 1);
        check("cont_lsu_rd", wb_rd, 4);
        idle_inputs();
        step();

        // Round-robin from reset: LSU, MDU, LSU, MDU
        do_reset();
        lsu_valid = 1; lsu_rd = 5'd5; lsu_data = 32'h5555_0000;
        mdu_valid = 1; mdu_rd = 5'd6; mdu_data = 32'h6666_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_lsu", obs_lsu_rdy, (i % 2 == 0));
            check("rr_mdu", obs_mdu_rdy, (i % 2 == 1));
            check("rr_en", wb_en, 1);
            check("rr_rd", wb_rd, (i % 2 == 0) ? 5 : 6);
        end
        idle_inputs();

        // Starvation: four ALU grants, one hold cycle, then MDU
        do_reset();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA5A5_A5A5;
        mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            step();
            check("starve_mdu_wait", obs_mdu_rdy, 0);
            check("starve_hold", pipe_hold, (i == 3));
        end
        alu_valid = 0;
        step();
        check("starve_mdu_rdy", obs_mdu_rdy, 1);
        check("starve_rd", wb_rd, 7);
        check("starve_data", wb_data, 32'h1234_5678);
        check("starve_hold_clr", pipe_hold, 0);
        idle_inputs();
        step();

        // rd=0 is accepted but not written; flush masks the ALU
        do_reset();
        lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h0000_DEAD;
        step();
        check("rd0_rdy", obs_lsu_rdy, 1);
        check("rd0_en", wb_en, 0);
        check("rd0_data", wb_data, 32'h0000_DEAD);
        flush = 1; alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2222_2222;
        lsu_rd = 5'd9; lsu_data = 32'h0000_0099;
        step();
        check("flush_lsu_rdy", obs_lsu_rdy, 1);
        check("flush_en", wb_en, 1);
        check("flush_rd", wb_rd, 9);
        idle_inputs();
        step();

        // Violation: ALU presented during the hold cycle
        do_reset();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA5A5_A5A5;
        mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h1234_5678;
        repeat (4) step();
        check("viol_hold", pipe_hold, 1);
        step();
        check("viol_mdu_rdy", obs_mdu_rdy, 1);
        check("viol_rd", wb_rd, 7);
        check("viol_err", err_alu_drop, 1);
        idle_inputs();
        repeat (3) step();
        check("viol_sticky", err_alu_drop, 1);

        // Reset in the middle of a transfer
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h0000_0044;
        step();
        check("mid_en_before", wb_en, 1);
        #1;
        check("mid_rdy_before", lsu_ready, 1);
        reset = 1'b0;
        #1;
        check("mid_rdy_rst", lsu_ready, 0);
        check("mid_en_rst", wb_en, 0);
        check("mid_err_rst", err_alu_drop, 0);
        idle_inputs();
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            flush     = ($urandom_range(7) == 0);
            alu_valid = m_hold ? ($urandom_range(15) == 0) : ($urandom_range(2) != 0);
            lsu_valid = $urandom_range(1);
            mdu_valid = $urandom_range(1);
            alu_rd    = 5'($urandom_range(31));
            lsu_rd    = 5'($urandom_range(31));
            mdu_rd    = 5'($urandom_range(31));
            alu_data  = $urandom;
            lsu_data  = $urandom;
            mdu_data  = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
